// File: rtl/jk_counter_pkg.sv
// Shared JK cell mode encodings and the modulo up/down next-state rule
// used by the steering logic of the JK counter.
package jk_counter_pkg;

    // {J,K} drive patterns for a JK cell
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Out-of-range states (cur >= modulus) recover to 0 going up and to
    // modulus-1 going down, so a faulted counter rejoins the cycle in one edge.
    function automatic logic [31:0] next_count(input logic [31:0] cur,
                                               input logic        up,
                                               input logic [31:0] modulus);
        logic [31:0] nxt;
        if (up)
            nxt = (cur >= modulus - 32'd1) ? 32'd0 : cur + 32'd1;
        else
            nxt = (cur == 32'd0 || cur >= modulus) ? modulus - 32'd1 : cur - 32'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Edge-triggered JK flip-flop cell with synchronous active-high clear.
module jk_cell
    import jk_counter_pkg::*;
(
    input  logic C,
    input  logic RESET,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qn
);

    logic q;

    always_ff @(posedge C) begin
        if (RESET) begin
            q <= 1'b0;
        end else begin
            case ({J, K})
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign Q  = q;
    assign Qn = ~q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-N up/down counter built from JK cells: steering logic picks each
// cell's J/K, plus terminal-count decode and a registered carry/borrow pulse.
module jk_sync_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             C,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             TC,
    output logic             CO
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    assign cnt_nxt = WIDTH'(next_count(32'(q), UP, 32'(MODULUS)));
    assign ld_val  = (D > MAXV) ? MAXV : D;

    // Count mode toggles only the bits that change; load forces each bit
    // directly. Reset bypasses steering and clears the cells.
    always_comb begin
        j = '0;
        k = '0;
        if (LOAD) begin
            j = ld_val;
            k = ~ld_val;
        end else if (EN) begin
            j = q ^ cnt_nxt;
            k = q ^ cnt_nxt;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .C     (C),
            .RESET (RESET),
            .J     (j[i]),
            .K     (k[i]),
            .Q     (q[i]),
            .Qn    (Qn[i])
        );
    end

    assign Q  = q;
    assign TC = EN & ~LOAD & ~RESET & (UP ? (q == MAXV) : (q == '0));

    always_ff @(posedge C) begin
        if (RESET) CO <= 1'b0;
        else       CO <= TC;
    end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Bench for jk_sync_counter: directed vector table, then random traffic
// checked against a modulo-arithmetic reference model.
module tb_jk_sync_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         C = 1'b0;
    logic         RESET = 1'b0, EN = 1'b0, UP = 1'b0, LOAD = 1'b0;
    logic [W-1:0] D = '0;
    logic [W-1:0] Q, Qn;
    logic         TC, CO;

    int checks = 0;
    int errors = 0;

    int   mq  = 0;
    logic mco = 1'b0;
    logic tc_s;

    typedef struct {
        logic rst, load, en, up;
        logic [W-1:0] d;
        int   q;
        logic tc, co;
    } vec_t;

    vec_t tbl[$];

    jk_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .C(C), .RESET(RESET), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
        .Q(Q), .Qn(Qn), .TC(TC), .CO(CO)
    );

    always #5 C = ~C;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check TC before the edge, advance the model,
    // then check Q/Qn/CO after the edge.
    task automatic step(input logic rst, load, en, up, input logic [W-1:0] d);
        logic exp_tc;
        @(negedge C);
        RESET = rst; LOAD = load; EN = en; UP = up; D = d;
        #1;
        tc_s   = TC;
        exp_tc = en && !load && !rst && (up ? (mq == M - 1) : (mq == 0));
        chk("tc_model", 32'(tc_s), 32'(exp_tc));
        if (rst) begin
            mq  = 0;
            mco = 1'b0;
        end else begin
            if (load)    mq = (int'(d) < M) ? int'(d) : M - 1;
            else if (en) mq = up ? (mq + 1) % M : (mq + M - 1) % M;
            mco = exp_tc;
        end
        @(posedge C);
        #1;
        chk("q_model",  32'(Q),  32'(mq));
        chk("qn_inv",   32'(Qn), 32'(W'(~Q)));
        chk("co_model", 32'(CO), 32'(mco));
    endtask

    function automatic vec_t mk(logic rst, load, en, up, logic [W-1:0] d,
                                int q, logic tc, logic co);
        vec_t v;
        v.rst = rst; v.load = load; v.en = en; v.up = up; v.d = d;
        v.q = q; v.tc = tc; v.co = co;
        return v;
    endfunction

    initial begin
        // reset with competing controls
        tbl.push_back(mk(1, 1, 1, 1, 4'd7, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 4'd7, 0, 0, 0));
        // count up 12 edges
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(0, 0, 1, 1, 4'd0, (i + 1) % 10, i == 9, i == 9));
        // load 3 then count down
        tbl.push_back(mk(0, 1, 0, 0, 4'd3, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'd0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'd0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'd0, 9, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 4'd0, 8, 0, 0));
        // saturating load, load beats enable
        tbl.push_back(mk(0, 1, 0, 1, 4'hC, 9, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 4'd5, 5, 0, 0));
        // enable gaps before a wrap
        tbl.push_back(mk(0, 1, 0, 1, 4'd8, 8, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'd0, 9, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'd0, 9, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'd0, 9, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'd0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 4'd0, 0, 0, 0));
        // reset on the wrap edge kills the carry
        tbl.push_back(mk(0, 1, 0, 1, 4'd8, 8, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'd0, 9, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'd0, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].d);
            chk($sformatf("tc_vec%0d", i), 32'(tc_s), 32'(tbl[i].tc));
            chk($sformatf("q_vec%0d", i),  32'(Q),    32'(tbl[i].q));
            chk($sformatf("co_vec%0d", i), 32'(CO),   32'(tbl[i].co));
        end

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
